// File: rtl/intersectie_secventiator.sv
// Phase scheduler for a two-axis (NS/EO) intersection with pedestrian and emergency phases.
// Latency: outputs registered, change on the same edge as the phase (one edge after timer==0 or urgenta_i rise).
// No backpressure: enable_i=0 freezes phase/timer/outputs; pedestrian requests are still latched and acked.
module intersectie_secventiator #(
  parameter int T_VERDE  = 20,
  parameter int T_GALBEN = 4,
  parameter int T_ROSU   = 2,
  parameter int T_PIETON = 10,
  parameter int CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       cerere_pieton_i,
  input  logic       urgenta_i,
  output logic [1:0] w_ns_o,
  output logic [1:0] w_eo_o,
  output logic       tranzit_ns_o,
  output logic       tranzit_eo_o,
  output logic       pieton_verde_o,
  output logic       cerere_ack_o,
  output logic [2:0] faza_o
);

  typedef enum logic [2:0] {
    S_ROSU      = 3'd0,
    S_VERDE_NS  = 3'd1,
    S_GALBEN_NS = 3'd2,
    S_VERDE_EO  = 3'd3,
    S_GALBEN_EO = 3'd4,
    S_PIETON    = 3'd5,
    S_URGENTA   = 3'd6
  } stare_t;

  localparam logic [CNT_W-1:0] LD_VERDE  = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] LD_GALBEN = CNT_W'(T_GALBEN - 1);
  localparam logic [CNT_W-1:0] LD_ROSU   = CNT_W'(T_ROSU - 1);
  localparam logic [CNT_W-1:0] LD_PIETON = CNT_W'(T_PIETON - 1);

  localparam logic [1:0] W_ROSU   = 2'b00;
  localparam logic [1:0] W_GALBEN = 2'b01;
  localparam logic [1:0] W_VERDE  = 2'b10;
  localparam logic [1:0] W_TOTROSU = 2'b11;

  stare_t           stare_q, stare_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             urm_eo_q, urm_eo_d;       // next green after ROSU: 0 = NS, 1 = EO
  logic             pend_q, pend_d;           // one outstanding pedestrian request
  logic             ped_facut_q, ped_facut_d; // last served phase was PIETON: prevents back-to-back PIETON
  logic             ack_q, ack_d;
  logic [1:0]       w_ns_q, w_ns_d, w_eo_q, w_eo_d;
  logic             tr_ns_q, tr_ns_d, tr_eo_q, tr_eo_d, ped_q, ped_d;

  // Next phase, timer, next-axis and pedestrian bookkeeping
  always_comb begin
    stare_d     = stare_q;
    timer_d     = timer_q;
    urm_eo_d    = urm_eo_q;
    ped_facut_d = ped_facut_q;

    // Remember whether the most recently served phase was the pedestrian one
    case (stare_q)
      S_PIETON: ped_facut_d = 1'b1;
      S_VERDE_NS, S_GALBEN_NS, S_VERDE_EO, S_GALBEN_EO: ped_facut_d = 1'b0;
      default: ped_facut_d = ped_facut_q;
    endcase

    if (urgenta_i) begin
      // Emergency overrides everything, timer is held
      stare_d = S_URGENTA;
    end else if (stare_q == S_URGENTA) begin
      // Leaving emergency always restarts with a full clearance and NS next
      stare_d  = S_ROSU;
      timer_d  = LD_ROSU;
      urm_eo_d = 1'b0;
    end else if (enable_i) begin
      if (timer_q != '0) begin
        timer_d = timer_q - CNT_W'(1);
      end else begin
        case (stare_q)
          S_ROSU: begin
            if (pend_q && !ped_facut_q) begin
              stare_d = S_PIETON;
              timer_d = LD_PIETON;
            end else begin
              stare_d = urm_eo_q ? S_VERDE_EO : S_VERDE_NS;
              timer_d = LD_VERDE;
            end
          end
          S_VERDE_NS: begin
            stare_d = S_GALBEN_NS;
            timer_d = LD_GALBEN;
          end
          S_GALBEN_NS: begin
            stare_d  = S_ROSU;
            timer_d  = LD_ROSU;
            urm_eo_d = 1'b1;
          end
          S_VERDE_EO: begin
            stare_d = S_GALBEN_EO;
            timer_d = LD_GALBEN;
          end
          S_GALBEN_EO: begin
            stare_d  = S_ROSU;
            timer_d  = LD_ROSU;
            urm_eo_d = 1'b0;
          end
          S_PIETON: begin
            stare_d = S_ROSU;
            timer_d = LD_ROSU;
          end
          default: begin
            stare_d = S_ROSU;
            timer_d = LD_ROSU;
          end
        endcase
      end
    end

    // Request latch: entering PIETON consumes the pending flag (and drops a same-edge request)
    ack_d  = cerere_pieton_i && !pend_q && (stare_q != S_PIETON);
    pend_d = pend_q;
    if ((stare_d == S_PIETON) && (stare_q != S_PIETON)) begin
      pend_d = 1'b0;
      ack_d  = 1'b0;
    end else if (ack_d) begin
      pend_d = 1'b1;
    end
  end

  // Light codes decoded from the next phase so they register together with it
  always_comb begin
    w_ns_d  = W_TOTROSU;
    w_eo_d  = W_TOTROSU;
    tr_ns_d = 1'b0;
    tr_eo_d = 1'b0;
    ped_d   = 1'b0;
    case (stare_d)
      S_VERDE_NS: begin
        w_ns_d = W_VERDE;
        w_eo_d = W_ROSU;
      end
      S_GALBEN_NS: begin
        w_ns_d  = W_GALBEN;
        w_eo_d  = W_ROSU;
        tr_ns_d = 1'b1;
      end
      S_VERDE_EO: begin
        w_ns_d = W_ROSU;
        w_eo_d = W_VERDE;
      end
      S_GALBEN_EO: begin
        w_ns_d  = W_ROSU;
        w_eo_d  = W_GALBEN;
        tr_eo_d = 1'b1;
      end
      S_PIETON: begin
        w_ns_d = W_ROSU;
        w_eo_d = W_ROSU;
        ped_d  = 1'b1;
      end
      default: begin
        w_ns_d = W_TOTROSU;
        w_eo_d = W_TOTROSU;
      end
    endcase
  end

  // State, timer and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stare_q     <= S_ROSU;
      timer_q     <= LD_ROSU;
      urm_eo_q    <= 1'b0;
      pend_q      <= 1'b0;
      ped_facut_q <= 1'b0;
      ack_q       <= 1'b0;
      w_ns_q      <= W_TOTROSU;
      w_eo_q      <= W_TOTROSU;
      tr_ns_q     <= 1'b0;
      tr_eo_q     <= 1'b0;
      ped_q       <= 1'b0;
    end else begin
      stare_q     <= stare_d;
      timer_q     <= timer_d;
      urm_eo_q    <= urm_eo_d;
      pend_q      <= pend_d;
      ped_facut_q <= ped_facut_d;
      ack_q       <= ack_d;
      w_ns_q      <= w_ns_d;
      w_eo_q      <= w_eo_d;
      tr_ns_q     <= tr_ns_d;
      tr_eo_q     <= tr_eo_d;
      ped_q       <= ped_d;
    end
  end

  assign w_ns_o         = w_ns_q;
  assign w_eo_o         = w_eo_q;
  assign tranzit_ns_o   = tr_ns_q;
  assign tranzit_eo_o   = tr_eo_q;
  assign pieton_verde_o = ped_q;
  assign cerere_ack_o   = ack_q;
  assign faza_o         = stare_q;

endmodule

// File: tb/tb_intersectie_secventiator.sv
module tb_intersectie_secventiator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, req = 1'b0, urg = 1'b0;
  logic [1:0] w_ns, w_eo;
  logic       tr_ns, tr_eo, ped, ack;
  logic [2:0] faza;

  intersectie_secventiator dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .cerere_pieton_i(req), .urgenta_i(urg),
    .w_ns_o(w_ns), .w_eo_o(w_eo), .tranzit_ns_o(tr_ns), .tranzit_eo_o(tr_eo),
    .pieton_verde_o(ped), .cerere_ack_o(ack), .faza_o(faza)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  wire [10:0] dut_o = {faza, w_ns, w_eo, tr_ns, tr_eo, ped, ack};

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h required %h", name, $time, got, exp);
  endtask

  // ---------------- reference model: phase + elapsed cycles ----------------
  int m_ph, m_el, m_last;
  bit m_next_eo, m_pend, m_ack;

  function automatic int dur(input int ph);
    case (ph)
      0: return 2;
      1, 3: return 20;
      2, 4: return 4;
      5: return 10;
      default: return 1;
    endcase
  endfunction

  function automatic logic [10:0] m_out();
    logic [1:0] a, b;
    logic tn, te, p;
    a = 2'd3; b = 2'd3; tn = 0; te = 0; p = 0;
    case (m_ph)
      1: begin a = 2; b = 0; end
      2: begin a = 1; b = 0; tn = 1; end
      3: begin a = 0; b = 2; end
      4: begin a = 0; b = 1; te = 1; end
      5: begin a = 0; b = 0; p = 1; end
      default: ;
    endcase
    return {3'(m_ph), a, b, tn, te, p, m_ack};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_last = 0; m_next_eo = 0; m_pend = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit e, input bit r, input bit u);
    bit set;
    int nph;
    set = r && !m_pend && m_ph != 5;
    nph = m_ph;
    if (m_ph >= 1 && m_ph <= 5) m_last = m_ph;
    if (u) nph = 6;
    else if (m_ph == 6) begin nph = 0; m_el = 0; m_next_eo = 0; end
    else if (e) begin
      m_el++;
      if (m_el == dur(m_ph)) begin
        m_el = 0;
        case (m_ph)
          0: nph = (m_pend && m_last != 5) ? 5 : (m_next_eo ? 3 : 1);
          1: nph = 2;
          2: begin nph = 0; m_next_eo = 1; end
          3: nph = 4;
          4: begin nph = 0; m_next_eo = 0; end
          default: nph = 0;
        endcase
      end
    end
    if (nph == 5 && m_ph != 5) begin m_pend = 0; set = 0; end
    else if (set) m_pend = 1;
    m_ack = set;
    m_ph = nph;
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after it
  task automatic step(input bit e, input bit r, input bit u);
    en = e; req = r; urg = u;
    @(posedge clk);
    model_step(e, r, u);
    #1;
    chk("model", dut_o, m_out());
  endtask

  localparam logic [10:0] RST_VAL = {3'd0, 2'd3, 2'd3, 4'b0000};

  task automatic do_reset();
    en = 0; req = 0; urg = 0;
    @(negedge clk); rst_n = 0;
    @(negedge clk);
    model_reset();
    chk("reset_state", dut_o, RST_VAL);
    rst_n = 1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int n;
    bit e, r, u;
    logic [2:0] fz;
    logic [1:0] wn, we;
    logic tn, te, p, a;
  } vec_t;

  function automatic vec_t v(int n, bit e, bit r, bit u, logic [2:0] fz, logic [1:0] wn, logic [1:0] we,
                             logic tn, logic te, logic p, logic a);
    vec_t x;
    x.n = n; x.e = e; x.r = r; x.u = u; x.fz = fz; x.wn = wn; x.we = we;
    x.tn = tn; x.te = te; x.p = p; x.a = a;
    return x;
  endfunction

  vec_t tbl[$];

  int acks, ped_entries, btb_err, last_np;
  logic [2:0] prev_fz;
  int ub;

  initial begin
    // default cycle
    tbl.push_back(v(1, 1,0,0, 0,3,3,0,0,0,0));
    tbl.push_back(v(1, 1,0,0, 1,2,0,0,0,0,0));
    tbl.push_back(v(19,1,0,0, 1,2,0,0,0,0,0));
    tbl.push_back(v(1, 1,0,0, 2,1,0,1,0,0,0));
    tbl.push_back(v(3, 1,0,0, 2,1,0,1,0,0,0));
    tbl.push_back(v(2, 1,0,0, 0,3,3,0,0,0,0));
    tbl.push_back(v(20,1,0,0, 3,0,2,0,0,0,0));
    tbl.push_back(v(4, 1,0,0, 4,0,1,0,1,0,0));
    tbl.push_back(v(2, 1,0,0, 0,3,3,0,0,0,0));
    tbl.push_back(v(1, 1,0,0, 1,2,0,0,0,0,0));
    // pedestrian pulse during VERDE_NS
    tbl.push_back(v(1, 1,1,0, 1,2,0,0,0,0,1));
    tbl.push_back(v(18,1,0,0, 1,2,0,0,0,0,0));
    tbl.push_back(v(4, 1,0,0, 2,1,0,1,0,0,0));
    tbl.push_back(v(2, 1,0,0, 0,3,3,0,0,0,0));
    tbl.push_back(v(10,1,0,0, 5,0,0,0,0,1,0));
    tbl.push_back(v(2, 1,0,0, 0,3,3,0,0,0,0));
    tbl.push_back(v(1, 1,0,0, 3,0,2,0,0,0,0));
    // emergency mid VERDE_EO
    tbl.push_back(v(5, 1,0,0, 3,0,2,0,0,0,0));
    tbl.push_back(v(7, 1,0,1, 6,3,3,0,0,0,0));
    tbl.push_back(v(2, 1,0,0, 0,3,3,0,0,0,0));
    tbl.push_back(v(1, 1,0,0, 1,2,0,0,0,0,0));
    // enable drop mid GALBEN_NS
    tbl.push_back(v(19,1,0,0, 1,2,0,0,0,0,0));
    tbl.push_back(v(3, 1,0,0, 2,1,0,1,0,0,0));
    tbl.push_back(v(5, 0,0,0, 2,1,0,1,0,0,0));
    tbl.push_back(v(1, 1,0,0, 2,1,0,1,0,0,0));
    tbl.push_back(v(2, 1,0,0, 0,3,3,0,0,0,0));
    tbl.push_back(v(1, 1,0,0, 3,0,2,0,0,0,0));

    do_reset();
    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].n; c++) begin
        step(tbl[k].e, tbl[k].r, tbl[k].u);
        chk($sformatf("vec%0d", k), dut_o,
            {tbl[k].fz, tbl[k].wn, tbl[k].we, tbl[k].tn, tbl[k].te, tbl[k].p, tbl[k].a});
      end
    end

    // held pedestrian request: one ack per PIETON, never back-to-back
    do_reset();
    acks = 0; ped_entries = 0; btb_err = 0; last_np = -1; prev_fz = 3'd0;
    for (int c = 0; c < 320; c++) begin
      step(1, 1, 0);
      if (ack) acks++;
      if (faza == 3'd5 && prev_fz != 3'd5) begin
        ped_entries++;
        if (last_np == 5) btb_err++;
      end
      if (faza != 3'd0 && faza != 3'd6) last_np = int'(faza);
      prev_fz = faza;
    end
    chk("held_ack_balance", 11'((acks - ped_entries == 0 || acks - ped_entries == 1) ? 1 : 0), 11'd1);
    chk("held_no_back_to_back", 11'(btb_err), 11'd0);
    chk("held_ped_phases", 11'(ped_entries >= 7 ? 1 : 0), 11'd1);

    // async reset mid VERDE_NS, with urgenta_i also low-priority against reset
    do_reset();
    for (int c = 0; c < 10; c++) step(1, 0, 0);
    #2 rst_n = 0;
    #1 chk("async_reset_immediate", dut_o, RST_VAL);
    model_reset();
    urg = 1;
    @(posedge clk); #1;
    chk("reset_beats_urgent", dut_o, RST_VAL);
    urg = 0;
    @(negedge clk); rst_n = 1;
    step(1, 0, 0);
    chk("restart_rosu", {8'(0), faza}, 11'd0);
    step(1, 0, 0);
    chk("restart_verde_ns", {8'(0), faza}, 11'd1);

    // urgent on the same edge as ROSU expiry
    do_reset();
    step(1, 0, 0);
    step(1, 0, 1);
    chk("urgent_beats_expiry", {8'(0), faza}, 11'd6);
    step(1, 0, 0);
    chk("urgent_exit_rosu", {8'(0), faza}, 11'd0);

    // randomized run against the model
    do_reset();
    ub = 0;
    for (int c = 0; c < 4000; c++) begin
      bit e, r, u;
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 24) == 0);
      if (ub > 0) ub--;
      else if ($urandom_range(0, 199) == 0) ub = $urandom_range(1, 8);
      u = (ub > 0);
      step(e, r, u);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/intersectie_secventiator.md
# intersectie_secventiator

- Phase scheduler for a two-axis intersection: North–South (NS) and East–West (EO).
- Cycles the axes through green, yellow and all-red clearance, and inserts a pedestrian-crossing phase on request.
- Forces all-red on an emergency input.
- Outputs drive the per-direction light drivers (`control_lumini_*`): `w_*_o` feeds `w_*` and `tranzit_*_o` feeds `tranzit_*`.

## Interface
- T_VERDE, 20 — green duration per axis, in clock cycles (≥1).
- T_GALBEN, 4 — yellow duration, in cycles (≥1).
- T_ROSU, 2 — all-red clearance duration, in cycles (≥1).
- T_PIETON, 10 — pedestrian phase duration, in cycles (≥1).
- CNT_W, 8 — timer width; must hold max(T_*)-1.
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  high: timer and state advance; low: freeze.
- cerere_pieton_i  in  1  pedestrian request, sampled every cycle (level or pulse).
- urgenta_i  in  1  emergency; high forces all-red.
- w_ns_o  out  2  NS light code: 00 red, 01 yellow, 10 green, 11 all-red.
- w_eo_o  out  2  EO light code, same encoding.
- tranzit_ns_o  out  1  high during the NS yellow phase.
- tranzit_eo_o  out  1  high during the EO yellow phase.
- pieton_verde_o  out  1  pedestrian green.
- cerere_ack_o  out  1  one-cycle pulse when a request is latched.
- faza_o  out  3  current phase: 0 ROSU, 1 VERDE_NS, 2 GALBEN_NS, 3 VERDE_EO, 4 GALBEN_EO, 5 PIETON, 6 URGENTA.

## Operation
- **States:** ROSU, VERDE_NS, GALBEN_NS, VERDE_EO, GALBEN_EO, PIETON, URGENTA.
- **Next-axis register** `urmator` (NS/EO) selects which green follows ROSU.
- **Phase timer:** down-counter loaded with T-1 on entry to a timed state; the state exits on the enabled edge where timer==0. Each timed state therefore lasts exactly T enabled cycles.
- **Transitions:**
  - VERDE_NS→GALBEN_NS→ROSU, with `urmator`:=EO.
  - VERDE_EO→GALBEN_EO→ROSU, with `urmator`:=NS.
  - ROSU expiry: if a request is pending → PIETON; else → VERDE_(`urmator`).
  - PIETON→ROSU; `urmator` is unchanged.
- **Output decode (per state):**
  - ROSU: both w=11.
  - VERDE_NS: ns=10, eo=00.
  - GALBEN_NS: ns=01, eo=00, tranzit_ns_o=1.
  - VERDE_EO and GALBEN_EO: mirror of the NS states.
  - PIETON: both w=00, pieton_verde_o=1.
  - URGENTA: both w=11.
- **Pedestrian request:**
  - A pending flag sets when cerere_pieton_i=1, the flag is clear, and the state is not PIETON.
  - cerere_ack_o pulses on the cycle after the flag sets.
  - The flag clears on PIETON entry.
  - A request present on the PIETON entry edge is dropped.
  - A request is at most one outstanding.
- **Emergency:**
  - urgenta_i=1 → URGENTA on the next edge from any state, regardless of enable_i.
  - Timer is held while in URGENTA.
  - On urgenta_i falling: → ROSU with a full T_ROSU, and `urmator`:=NS.
  - The pending pedestrian flag is preserved.
- **enable_i=0:** state, timer, `urmator` and outputs are frozen. A pedestrian request is still latched and acked.
- **Reset (asynchronous, immediate):**
  - State ROSU, timer=T_ROSU-1, `urmator`=NS, pending=0.
  - w_ns_o=11, w_eo_o=11, tranzit_*=0, pieton_verde_o=0, cerere_ack_o=0, faza_o=0.
  - Reset mid-phase abandons the phase with no yellow.

## Timing
- All outputs are registered and change on the same edge as the state; there is no combinational path from inputs to outputs.
- Transition latency: one edge after timer==0, or one edge after urgenta_i rises.
- **Defaults, after reset release:**
  - ROSU for edges 1–2.
  - VERDE_NS visible after edge 2, for 20 cycles.
  - GALBEN_NS for 4 cycles, then ROSU for 2.
  - Next VERDE_EO visible after edge 28.
  - Full cycle with no requests: 52 cycles.
- Pedestrian insertion adds T_PIETON+T_ROSU = 12 cycles at the next ROSU expiry.
- **Boundaries:**
  - T=1 gives a one-cycle state.
  - Urgent and timer expiry on the same edge: URGENTA wins.
  - urgenta_i and rst_n_i low together: reset wins.

## Test plan
- Reset release, enable=1, no inputs → faza sequence 0,1,2,0,3,4,0 with durations 2,20,4,2,20,4; tranzit_ns_o high exactly 4 cycles.
- Pulse cerere_pieton_i for 1 cycle during VERDE_NS:
  - cerere_ack_o pulses once.
  - After GALBEN_NS and ROSU: PIETON for 10 cycles, both w=00, pieton_verde_o=1.
  - Then ROSU for 2, then VERDE_EO.
- Hold cerere_pieton_i high continuously → exactly one ack per PIETON phase; PIETON alternates with a full axis green and never repeats back-to-back.
- Raise urgenta_i mid VERDE_EO:
  - Both w=11, faza=6 after one edge.
  - Hold 7 cycles, release → ROSU for 2, then VERDE_NS.
- Drop enable_i for 5 cycles mid GALBEN_NS → outputs frozen; the phase resumes with its remaining count, total yellow still 4 enabled cycles.
- Assert rst_n_i low asynchronously mid VERDE_NS (between edges) → outputs immediately at reset values; on release the sequence restarts from ROSU.
